// File: rtl/mips_pkg.sv
// Shared ALU control codes and execute-stage helper types so the ALU control
// decoder and the multiply/divide unit agree on encodings.
package mips_pkg;

    localparam logic [5:0] ALU_AND   = 6'd0;
    localparam logic [5:0] ALU_OR    = 6'd1;
    localparam logic [5:0] ALU_ADD   = 6'd2;
    localparam logic [5:0] ALU_ADDU  = 6'd3;
    localparam logic [5:0] ALU_XOR   = 6'd4;
    localparam logic [5:0] ALU_SUBU  = 6'd5;
    localparam logic [5:0] ALU_SUB   = 6'd6;
    localparam logic [5:0] ALU_SLT   = 6'd7;
    localparam logic [5:0] ALU_SLTU  = 6'd8;
    localparam logic [5:0] ALU_SLL   = 6'd9;
    localparam logic [5:0] ALU_SRL   = 6'd10;
    localparam logic [5:0] ALU_SRA   = 6'd11;
    localparam logic [5:0] ALU_NOR   = 6'd12;
    localparam logic [5:0] ALU_LUI   = 6'd13;
    localparam logic [5:0] ALU_MULT  = 6'd15;
    localparam logic [5:0] ALU_MULTU = 6'd16;
    localparam logic [5:0] ALU_DIV   = 6'd17;
    localparam logic [5:0] ALU_DIVU  = 6'd18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv(input logic [5:0] code);
        return (code == ALU_MULT) || (code == ALU_MULTU) ||
               (code == ALU_DIV)  || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide. Works on unsigned magnitudes.
module muldiv_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] acc_hi,
    input  logic [DATA_WIDTH-1:0] acc_lo,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] next_hi,
    output logic [DATA_WIDTH-1:0] next_lo
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;
    logic                  fits;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_hi = acc_hi;
        next_lo = acc_lo;
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[DATA_WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // The remainder is always below the divisor, so the difference fits in DATA_WIDTH bits.
        diff    = shifted[DATA_WIDTH-1:0] - operand;

        if (is_div) begin
            next_hi = fits ? diff : shifted[DATA_WIDTH-1:0];
            next_lo = {acc_lo[DATA_WIDTH-2:0], fits};
        end else begin
            next_hi = sum[DATA_WIDTH:1];
            next_lo = {sum[0], acc_lo[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. One operation at a time behind
// start/busy/done; mthi/mtlo writes are accepted only while idle.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            alu_ctrl_in,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int                CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    muldiv_state_t state, state_next;

    logic [CNT_W-1:0]        count;
    logic [DATA_WIDTH-1:0]   acc_hi, acc_lo, operand;
    logic [DATA_WIDTH-1:0]   next_hi, next_lo;
    logic                    is_div, neg_res, neg_rem, div_zero;

    logic                    accept, op_signed, op_div, rs_neg, rt_neg;
    logic [DATA_WIDTH-1:0]   rs_mag, rt_mag;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quot_fix, rem_fix;

    assign accept    = (state == IDLE) && start && is_muldiv(alu_ctrl_in);
    assign op_signed = (alu_ctrl_in == ALU_MULT) || (alu_ctrl_in == ALU_DIV);
    assign op_div    = (alu_ctrl_in == ALU_DIV)  || (alu_ctrl_in == ALU_DIVU);
    assign rs_neg    = op_signed && rs_data[DATA_WIDTH-1];
    assign rt_neg    = op_signed && rt_data[DATA_WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_data : rs_data;
    assign rt_mag    = rt_neg ? -rt_data : rt_data;
    assign busy      = (state != IDLE);

    // Divide by zero leaves remainder = |rs|, so only the quotient needs overriding.
    assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_fix = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

    muldiv_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (next_hi),
        .next_lo (next_lo)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (count == LAST_ITER) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        count    <= '0;
                        is_div   <= op_div;
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        div_zero <= (rt_data == '0);
                        acc_hi   <= '0;
                        acc_lo   <= op_div ? rs_mag : rt_mag;
                        operand  <= op_div ? rt_mag : rs_mag;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                CALC: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    count  <= count + CNT_W'(1);
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                        lo <= prod_fix[DATA_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO reference.
module tb_mul_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   alu_ctrl_in = '0;
    logic         start = 1'b0;
    logic [W-1:0] rs_data = '0, rt_data = '0;
    logic         wr_hi = 1'b0, wr_lo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_ctrl_in (alu_ctrl_in),
        .start       (start),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result as {HI, LO}, straight from 64-bit integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [5:0] code, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ref_result = '0;
        case (code)
            ALU_MULT:  begin q = sa * sb; ref_result = q; end
            ALU_MULTU: ref_result = ua * ub;
            ALU_DIV: begin
                if (b == '0) ref_result = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_result = {r[31:0], q[31:0]};
                end
            end
            ALU_DIVU: begin
                if (b == '0) ref_result = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    ref_result = {ur[31:0], uq[31:0]};
                end
            end
            default: ref_result = '0;
        endcase
    endfunction

    // Called just after a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string tag, input logic [5:0] code, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit scramble, input bit inject);
        logic [63:0]  exp;
        logic [W-1:0] prev_hi, prev_lo;
        int           lat, busy_cnt;
        exp     = ref_result(code, a, b);
        prev_hi = hi;
        prev_lo = lo;
        alu_ctrl_in = code;
        rs_data     = a;
        rt_data     = b;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        if (scramble) begin
            rs_data = $urandom;
            rt_data = $urandom;
        end
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == 10 && inject) begin
                start       = 1'b1;
                alu_ctrl_in = ALU_MULTU;
                rs_data     = $urandom;
                rt_data     = $urandom;
                wr_hi       = 1'b1;
                wr_lo       = 1'b1;
                wr_data     = $urandom;
            end
            if (lat == 11) begin
                start = 1'b0;
                wr_hi = 1'b0;
                wr_lo = 1'b0;
            end
            if (lat == 16) begin
                check($sformatf("%s hi_hold", tag), hi, prev_hi);
                check($sformatf("%s lo_hold", tag), lo, prev_lo);
            end
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s latency", tag), W'(lat), W'(33));
        check($sformatf("%s busy_cycles", tag), W'(busy_cnt), W'(33));
        check($sformatf("%s done", tag), W'(done), W'(1));
        check($sformatf("%s busy_at_done", tag), W'(busy), W'(0));
        check($sformatf("%s hi", tag), hi, exp[63:32]);
        check($sformatf("%s lo", tag), lo, exp[31:0]);
    endtask

    initial begin
        logic [W-1:0] a, b, saved_hi, saved_lo;
        logic [5:0]   code;
        int           done_cnt;

        repeat (2) @(negedge clk);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset hi", hi, '0);
        check("reset lo", lo, '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", W'(done), W'(0));
        run_op("mult_neg", ALU_MULT, -32'sd3, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        run_op("mult_min_min", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clk);
        run_op("div_neg", ALU_DIV, -32'sd7, 32'd2, 1'b1, 1'b0);
        @(negedge clk);
        run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        @(negedge clk);
        run_op("div_overflow", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        run_op("divu_by_zero", ALU_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        run_op("div_neg_by_zero", ALU_DIV, -32'sd5, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        run_op("div_rem_neg", ALU_DIV, -32'sd100, -32'sd7, 1'b0, 1'b0);
        @(negedge clk);

        run_op("busy_ignores", ALU_DIVU, 32'd1000, 32'd3, 1'b0, 1'b1);
        @(negedge clk);

        saved_hi = hi;
        wr_lo   = 1'b1;
        wr_data = 32'h0000_1234;
        @(negedge clk);
        wr_lo = 1'b0;
        check("mtlo lo", lo, 32'h0000_1234);
        check("mtlo hi_kept", hi, saved_hi);
        wr_hi   = 1'b1;
        wr_lo   = 1'b1;
        wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check("mthi_mtlo hi", hi, 32'hCAFE_F00D);
        check("mthi_mtlo lo", lo, 32'hCAFE_F00D);

        saved_hi = hi;
        saved_lo = lo;
        start       = 1'b1;
        alu_ctrl_in = ALU_ADD;
        rs_data     = 32'd9;
        rt_data     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("bad_code busy", W'(busy), W'(0));
        @(negedge clk);
        check("bad_code done", W'(done), W'(0));
        check("bad_code lo", lo, saved_lo);

        // Start and mthi in the same cycle: the start must win.
        wr_hi   = 1'b1;
        wr_data = 32'h5555_AAAA;
        run_op("start_beats_mthi", ALU_MULTU, 32'd3, 32'd4, 1'b0, 1'b0);
        run_op("back_to_back", ALU_DIV, 32'd77, -32'sd5, 1'b0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0:       code = ALU_MULT;
                1:       code = ALU_MULTU;
                2:       code = ALU_DIV;
                default: code = ALU_DIVU;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 50));
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), code, a, b, 1'b1, 1'b0);
            @(negedge clk);
        end

        alu_ctrl_in = ALU_DIV;
        rs_data     = 32'd1234;
        rt_data     = 32'd11;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        check("abort hi", hi, '0);
        check("abort lo", lo, '0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (done) done_cnt++;
        end
        check("abort no_done", W'(done_cnt), W'(0));
        check("abort idle", W'(busy), W'(0));
        run_op("after_reset", ALU_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
